// File: rtl/pattern_merge_bist_sequencer.sv
// BIST sequencer: LFSR stimulus, settle wait, MISR response compaction.
// Ports: blif_clk_net/blif_reset_net, start/abort/seed_load/seed_val in;
// dut_in out, dut_resp in; capture_strobe/busy/done/signature/pat_count out.
module pattern_merge_bist_sequencer #(
    parameter int unsigned IN_W      = 11,
    parameter int unsigned OUT_W     = 9,
    parameter int unsigned N_PAT     = 256,
    parameter int unsigned SETTLE    = 3,
    parameter logic [IN_W-1:0]  LFSR_TAPS = 'h500,
    parameter logic [IN_W-1:0]  LFSR_SEED = 'h001,
    parameter logic [OUT_W-1:0] MISR_POLY = 'h021
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [IN_W-1:0]  seed_val,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_resp,
    output logic             capture_strobe,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pat_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t           state, state_d;
    logic [3:0]       cnt, cnt_d;
    logic [IN_W-1:0]  lfsr, lfsr_d;
    logic [IN_W-1:0]  seed_reg, seed_d;
    logic [IN_W-1:0]  dut_in_d;
    logic [OUT_W-1:0] sig_d;
    logic [15:0]      pat_d;
    logic             busy_d, done_d, cap_d;

    logic [IN_W-1:0]  lfsr_nx;
    logic [OUT_W-1:0] sig_nx;
    logic [15:0]      pat_inc;
    logic             running;

    assign lfsr_nx = {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign sig_nx  = {signature[OUT_W-2:0], 1'b0}
                   ^ (signature[OUT_W-1] ? MISR_POLY : '0)
                   ^ dut_resp;
    assign pat_inc = pat_count + 16'd1;
    assign running = (state == S_APPLY) || (state == S_SETTLE)
                  || (state == S_CAPTURE);

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lfsr           <= '0;
            seed_reg       <= LFSR_SEED;
            dut_in         <= '0;
            signature      <= '0;
            pat_count      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            capture_strobe <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            lfsr           <= lfsr_d;
            seed_reg       <= seed_d;
            dut_in         <= dut_in_d;
            signature      <= sig_d;
            pat_count      <= pat_d;
            busy           <= busy_d;
            done           <= done_d;
            capture_strobe <= cap_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        lfsr_d   = lfsr;
        seed_d   = seed_reg;
        dut_in_d = dut_in;
        sig_d    = signature;
        pat_d    = pat_count;
        busy_d   = busy;
        done_d   = done;
        cap_d    = 1'b0;

        unique case (state)
            S_IDLE, S_DONE: begin
                // New seed lands after this edge, so a same-cycle start
                // still launches with the previous seed.
                if (seed_load)
                    seed_d = (seed_val == '0) ? IN_W'(1) : seed_val;
                if (abort) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b0;
                    busy_d   = 1'b0;
                    dut_in_d = '0;
                end else if (start) begin
                    state_d  = S_APPLY;
                    lfsr_d   = seed_reg;
                    dut_in_d = seed_reg;
                    sig_d    = '0;
                    pat_d    = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_APPLY: begin
                if (SETTLE == 0) begin
                    state_d = S_CAPTURE;
                    cap_d   = 1'b1;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = 4'(SETTLE);
                end
            end
            S_SETTLE: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_d = S_CAPTURE;
                    cap_d   = 1'b1;
                end
            end
            S_CAPTURE: begin
                sig_d  = sig_nx;
                pat_d  = pat_inc;
                lfsr_d = lfsr_nx;
                if (pat_inc == 16'(N_PAT)) begin
                    // dut_in keeps the last applied pattern in DONE
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = S_APPLY;
                    dut_in_d = lfsr_nx;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes partial signature/count and drops to idle.
        if (running && abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            lfsr_d   = lfsr;
            dut_in_d = '0;
            sig_d    = signature;
            pat_d    = pat_count;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cap_d    = 1'b0;
        end
    end

endmodule
